// File: rtl/state_row_packer.sv
// Byte-transpose packer: LANES column words per beat fill a COLS-column block, drained one row per cycle.
// Latency: row 0 valid the cycle after the last beat; ping-pong banks, in_ready drops only when the fill bank is still draining.
module state_row_packer #(
  parameter int WORD_W = 32,
  parameter int LANES  = 2,
  parameter int COLS   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WORD_W-1:0]       in_words,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*8-1:0]             out_row,
  output logic [$clog2(WORD_W/8)-1:0]   out_row_idx,
  output logic                          out_last
);
  localparam int ROWS  = WORD_W / 8;
  localparam int BEATS = COLS / LANES;
  localparam int RIW   = $clog2(ROWS);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [WORD_W-1:0] bank [2][COLS];
  logic [1:0]        full;
  logic              fb;
  logic              db;
  logic [BCW-1:0]    bc;
  logic [RIW-1:0]    rc;
  logic              in_fire;
  logic              out_fire;
  logic              fill_done;
  logic              drain_done;

  // Handshake readiness depends on registered state only, never on out_ready.
  assign in_ready    = !full[fb];
  assign out_valid   = full[db];
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign fill_done   = in_fire && (bc == BCW'(BEATS - 1));
  assign drain_done  = out_fire && (rc == RIW'(ROWS - 1));
  assign out_row_idx = rc;
  assign out_last    = out_valid && (rc == RIW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      fb   <= 1'b0;
      db   <= 1'b0;
      bc   <= '0;
      rc   <= '0;
    end else if (clear) begin
      full <= '0;
      fb   <= 1'b0;
      db   <= 1'b0;
      bc   <= '0;
      rc   <= '0;
    end else begin
      if (in_fire)
        bc <= fill_done ? '0 : bc + BCW'(1);
      // Fill and drain always target different banks, so both may complete together.
      if (fill_done) begin
        full[fb] <= 1'b1;
        fb       <= ~fb;
      end
      if (out_fire)
        rc <= drain_done ? '0 : rc + RIW'(1);
      if (drain_done) begin
        full[db] <= 1'b0;
        db       <= ~db;
      end
    end
  end

  // Bank storage is deliberately not reset; full flags gate its visibility.
  always_ff @(posedge clk) begin
    if (in_fire && !clear) begin
      for (int c = 0; c < COLS; c++) begin
        if (BCW'(c / LANES) == bc)
          bank[fb][c] <= in_words[(LANES-1-(c%LANES))*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    out_row = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (rc == RIW'(r))
          out_row[(COLS-1-c)*8 +: 8] = bank[db][c][WORD_W-1-8*r -: 8];
      end
    end
  end
endmodule

// File: tb/tb_state_row_packer.sv
// Scoreboard bench for state_row_packer: default 32/2/4 instance plus 32/2/2 and 64/1/4 variants.
module tb_state_row_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_words;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_row;
  logic [1:0]  out_row_idx;
  logic        out_last;

  logic        v2, r2, ov2, last2;
  logic [63:0] w2;
  logic [15:0] row2;
  logic [1:0]  idx2;

  logic        v3, r3, ov3, last3;
  logic [63:0] w3;
  logic [31:0] row3;
  logic [2:0]  idx3;

  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;

  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic [31:0] row;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [18:0] q2[$];
  logic [18:0] e2;
  logic [35:0] q3[$];
  logic [35:0] e3;

  always #5 clk = ~clk;

  state_row_packer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_words(in_words),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last)
  );

  state_row_packer #(.WORD_W(32), .LANES(2), .COLS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(tie0),
    .in_valid(v2), .in_ready(r2), .in_words(w2),
    .out_valid(ov2), .out_ready(tie1), .out_row(row2),
    .out_row_idx(idx2), .out_last(last2)
  );

  state_row_packer #(.WORD_W(64), .LANES(1), .COLS(4)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(tie0),
    .in_valid(v3), .in_ready(r3), .in_words(w3),
    .out_valid(ov3), .out_ready(tie1), .out_row(row3),
    .out_row_idx(idx3), .out_last(last3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: a row counts only when it is actually consumed.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      if (q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL extra_row: got %h with nothing expected", out_row);
      end else begin
        me = q.pop_front();
        chk("row", 64'(out_row), 64'(me.row));
        chk("row_idx", 64'(out_row_idx), 64'(me.idx));
        chk("last", 64'(out_last), 64'(me.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov2) begin
      if (q2.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL extra_row_u2: got %h with nothing expected", row2);
      end else begin
        e2 = q2.pop_front();
        chk("u2_row_idx_last", 64'({row2, idx2, last2}), 64'(e2));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov3) begin
      if (q3.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL extra_row_u3: got %h with nothing expected", row3);
      end else begin
        e3 = q3.pop_front();
        chk("u3_row_idx_last", 64'({row3, idx3, last3}), 64'(e3));
      end
    end
  end

  // Hand-computed transposes of the three test blocks.
  task automatic push_blk(input int blk, input int n);
    logic [31:0] rows [4];
    case (blk)
      0: rows = '{32'h004488CC, 32'h115599DD, 32'h2266AAEE, 32'h3377BBFF};
      1: rows = '{32'h0189FE76, 32'h23ABDC54, 32'h45CDBA32, 32'h67EF9810};
      default: rows = '{32'hDECA129A, 32'hADFE34BC, 32'hBEBA56DE, 32'hEFBE78F0};
    endcase
    for (int i = 0; i < n; i++)
      q.push_back('{row: rows[i], idx: 2'(i), last: (i == 3)});
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_words = {a, b};
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_blk(input int blk);
    case (blk)
      0: begin send(32'h00112233, 32'h44556677); send(32'h8899AABB, 32'hCCDDEEFF); end
      1: begin send(32'h01234567, 32'h89ABCDEF); send(32'hFEDCBA98, 32'h76543210); end
      default: begin send(32'hDEADBEEF, 32'hCAFEBABE); send(32'h12345678, 32'h9ABCDEF0); end
    endcase
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q.size() != 0 || q2.size() != 0 || q3.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, 64'(q.size() + q2.size() + q3.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] m3(input logic [63:0] w [4], input int r);
    logic [31:0] row;
    for (int c = 0; c < 4; c++)
      row[(3-c)*8 +: 8] = w[c][63-8*r -: 8];
    return {row, 3'(r), (r == 7)};
  endfunction

  task automatic send3(input logic [63:0] w [4]);
    for (int r = 0; r < 8; r++) q3.push_back(m3(w, r));
    for (int c = 0; c < 4; c++) begin
      int n = 0;
      v3 = 1'b1;
      w3 = w[c];
      @(negedge clk);
      while (!r3 && n < 60) begin
        n++;
        @(negedge clk);
      end
      chk("u3_in_ready_wait", 64'(r3), 64'd1);
      @(posedge clk);
      #1 v3 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int n;
    logic [63:0] wa [4];
    logic [63:0] wb [4];
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_words = '0; out_ready = 1'b1;
    v2 = 1'b0; w2 = '0; v3 = 1'b0; w3 = '0;

    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_row_idx", 64'(out_row_idx), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 basic, including first-row latency.
    push_blk(0, 4);
    send(32'h00112233, 32'h44556677);
    chk("t1_no_early_valid", 64'(out_valid), 64'd0);
    send(32'h8899AABB, 32'hCCDDEEFF);
    chk("t1_latency_valid", 64'(out_valid), 64'd1);
    chk("t1_latency_row0", 64'(out_row), 64'h004488CC);
    wait_drain("t1_drained");

    // T2 three blocks streamed; output rows must be contiguous.
    push_blk(0, 4); push_blk(1, 4); push_blk(2, 4);
    fork
      begin send_blk(0); send_blk(1); send_blk(2); end
      begin
        n = 0;
        while (!out_valid && n < 40) begin n++; @(negedge clk); end
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
          if (out_valid) cnt++;
          @(negedge clk);
        end
        chk("t2_contiguous_rows", 64'(cnt), 64'd12);
      end
    join
    wait_drain("t2_drained");

    // T3 back-pressure: second block fills, then input stalls and row 0 holds.
    out_ready = 1'b0;
    push_blk(1, 4); push_blk(2, 4);
    send_blk(1);
    send_blk(2);
    @(negedge clk);
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("t3_row_hold", 64'(out_row), 64'h0189FE76);
      chk("t3_idx_hold", 64'(out_row_idx), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t3_drained");

    // T4 clear after a single beat, then clear after two rows drained.
    send(32'h11111111, 32'h22222222);
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("t4a_out_valid", 64'(out_valid), 64'd0);
    chk("t4a_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    push_blk(0, 4);
    send_blk(0);
    wait_drain("t4a_drained");
    push_blk(1, 2);
    send_blk(1);
    @(posedge clk);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("t4b_out_valid", 64'(out_valid), 64'd0);
    chk("t4b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    push_blk(2, 4);
    send_blk(2);
    wait_drain("t4b_drained");

    // T5 asynchronous reset while row 2 is presented.
    push_blk(1, 2);
    send_blk(1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_out_valid_async", 64'(out_valid), 64'd0);
    chk("t5_in_ready_async", 64'(in_ready), 64'd1);
    chk("t5_out_last_async", 64'(out_last), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    push_blk(0, 4);
    send_blk(0);
    wait_drain("t5_drained");

    // T6a two-column variant: one beat gives four 16-bit rows.
    q2.push_back({16'hA1E5, 2'd0, 1'b0});
    q2.push_back({16'hB2F6, 2'd1, 1'b0});
    q2.push_back({16'hC307, 2'd2, 1'b0});
    q2.push_back({16'hD418, 2'd3, 1'b1});
    v2 = 1'b1;
    w2 = {32'hA1B2C3D4, 32'hE5F60718};
    n = 0;
    @(negedge clk);
    while (!r2 && n < 60) begin n++; @(negedge clk); end
    chk("u2_in_ready_wait", 64'(r2), 64'd1);
    @(posedge clk); #1 v2 = 1'b0;
    wait_drain("t6a_drained");

    // T6b 64-bit single-lane variant, two blocks back to back.
    wa = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    wb = '{64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h8899AABBCCDDEEFF, 64'h0011223344556677};
    send3(wa);
    send3(wb);
    wait_drain("t6b_drained");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
